sdram_command_responder: RTL and testbench
==========================================

Name: sdram_command_responder

Overview:
- Target side of the SDRAM command interface (command/data_address/data_write → data_read/data_read_valid/data_write_done) that our frame-buffer arbiter drives.
- Backed by on-chip block RAM instead of external SDRAM.
- Drop-in stand-in for the as4c4m16sa controller during bring-up and simulation, so the MIPI→memory→pixel path runs without the physical SDRAM.
- Reproduces burst, latency and per-word handshake timing with configurable parameters.

Parameters:
ADDR_WIDTH, 12, internal memory depth is 2^ADDR_WIDTH 16-bit words; low ADDR_WIDTH bits of data_address used
READ_BURST_LENGTH, 8, words returned per read command (1..256)
WRITE_BURST_LENGTH, 8, words accepted per write command (1..256)
READ_LATENCY, 4, cycles from first cycle command==2 is visible to first data_read_valid (>=2)
WRITE_INTERVAL, 2, cycles between successive data_write_done pulses (>=2)

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high
command  input  2  0 idle, 1 write burst, 2 read burst, 3 reserved (treated as idle)
data_address  input  22  burst base word address, sampled when a burst starts
data_write  input  16  write data, sampled in the cycle data_write_done is high
data_read  output  16  read data, meaningful only when data_read_valid is high
data_read_valid  output  1  one pulse per read word, consecutive within a burst
data_write_done  output  1  one pulse per written word
busy  output  1  high from burst start until the cycle after the last pulse

Behaviour:
- Reset: state IDLE; data_read=0, data_read_valid=0, data_write_done=0, busy=0; counters cleared. Memory contents are not cleared. Reset mid-burst aborts the burst immediately. A partially written burst keeps the words already written.
- States: IDLE, WRITE, READ_WAIT, READ_DATA.
- IDLE: sample command each edge. Let C be the cycle command first shows 1 or 2.
  - At the edge ending C: latch base = data_address[ADDR_WIDTH-1:0], clear the word counter, set busy.
  - Go to WRITE (command 1) or READ_WAIT (command 2).
  - Command 0 or 3: stay in IDLE.
- WRITE:
  - data_write_done is high, registered, in cycles C+WRITE_INTERVAL*(k+1) for k=0..WRITE_BURST_LENGTH-1, and low otherwise.
  - At the edge ending each of those cycles: mem[base+k] <= data_write.
  - After word WRITE_BURST_LENGTH-1: go to IDLE, busy=0 from the next cycle.
- READ_WAIT → READ_DATA:
  - data_read_valid is high in cycles C+READ_LATENCY+k for k=0..READ_BURST_LENGTH-1 (back-to-back, no gaps).
  - data_read = mem[base+k] in those cycles.
  - Memory read is registered, so the address is issued one cycle ahead.
  - After the last word: go to IDLE, busy=0 from the next cycle.
- Address arithmetic: base+k is modulo 2^ADDR_WIDTH. Bursts wrap at the end of memory, not at a burst-aligned boundary. data_address bits above ADDR_WIDTH are ignored.
- Command is evaluated only in IDLE. Changes of command or data_address during a burst are ignored, and the burst runs to completion.
- Earliest next command: the initiator drops command in the cycle after the last pulse, so a new command seen in IDLE at cycle N+2 or later is accepted with no turnaround penalty. A command held at a non-zero value into IDLE starts a new burst immediately.
- Read-after-write to the same address returns the newly written data. The write completes before IDLE is re-entered.
- data_read_valid and data_write_done are never high in the same cycle.
- Implementation size is roughly 150–250 lines (FSM, two counters, latency counter, RAM inference).

Test Plan:
- Reset, then idle for 10 cycles with command=0 → all outputs 0; busy=0.
- Write burst at address 0x000010 with data_write stepping 0x1000..0x1007 each time data_write_done pulses:
  - done pulses at C+2, C+4, …, C+16;
  - busy falls at C+17.
  - Read burst at 0x000010 → data_read_valid at C'+4..C'+11; data 0x1000..0x1007 in order.
- Wrap-around: write 8 words at 0x000FFC (ADDR_WIDTH=12) → words land at 0xFFC..0xFFF, then 0x000..0x003. Reading at 0x000000 returns the last four written values first.
- High-address aliasing: write at 0x3FF010, read at 0x000010 → identical data.
- Mid-burst disturbance: change command to 2 and data_address to 0x123 during a write burst → write still completes 8 words at the original base; no data_read_valid pulse until a new read is issued from IDLE.
- Reset asserted at C+5 of a read burst → data_read_valid=0 and busy=0 the next cycle. A following write/read pair at 0x000020 behaves as in scenario 2.

Source files
------------

// File: rtl/sdram_command_responder.sv
// Block-RAM stand-in for the SDRAM controller: answers write/read burst
// commands with the same per-word handshake, latency and burst timing as
// the real device, so the frame-buffer path can run without external memory.
module sdram_command_responder #(
    parameter int ADDR_WIDTH         = 12,
    parameter int READ_BURST_LENGTH  = 8,
    parameter int WRITE_BURST_LENGTH = 8,
    parameter int READ_LATENCY       = 4,
    parameter int WRITE_INTERVAL     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  command,
    input  logic [21:0] data_address,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    output logic        data_read_valid,
    output logic        data_write_done,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = 9;
    localparam int IW    = $clog2(WRITE_INTERVAL + 1);
    localparam int LW    = $clog2(READ_LATENCY + 1);

    localparam logic [CW-1:0] WLAST = CW'(WRITE_BURST_LENGTH - 1);
    localparam logic [CW-1:0] RLAST = CW'(READ_BURST_LENGTH - 1);
    localparam logic [IW-1:0] ILAST = IW'(WRITE_INTERVAL - 1);
    localparam logic [LW-1:0] LLAST = LW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_DATA
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] base, base_d;
    logic [CW-1:0]         wcnt, wcnt_d;
    logic [CW-1:0]         rcnt, rcnt_d;
    logic [IW-1:0]         icnt, icnt_d;
    logic [LW-1:0]         lcnt, lcnt_d;
    logic                  done_d;
    logic                  valid_d;
    logic                  rd_en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  start;

    logic [15:0] mem [DEPTH];

    // Address bits above the memory depth alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^data_address[21:ADDR_WIDTH];

    assign start = (command == 2'd1) || (command == 2'd2);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode; commands are only looked at while idle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (command == 2'd1)      next_state = WRITE;
                else if (command == 2'd2) next_state = READ_WAIT;
            end
            WRITE: begin
                if (data_write_done && (wcnt == WLAST)) next_state = IDLE;
            end
            READ_WAIT: begin
                if (lcnt == LLAST) next_state = READ_DATA;
            end
            READ_DATA: begin
                if (rcnt == RLAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Per-state datapath control: next values of counters and strobes.
    // The read address is issued one cycle before each valid beat because
    // the RAM output is registered.
    always_comb begin
        base_d  = base;
        wcnt_d  = wcnt;
        rcnt_d  = rcnt;
        icnt_d  = icnt;
        lcnt_d  = lcnt;
        done_d  = 1'b0;
        valid_d = 1'b0;
        rd_en   = 1'b0;
        we      = 1'b0;
        rd_addr = base;
        wr_addr = base + ADDR_WIDTH'(wcnt);
        unique case (state)
            IDLE: begin
                if (start) begin
                    base_d = data_address[ADDR_WIDTH-1:0];
                    wcnt_d = '0;
                    rcnt_d = '0;
                    icnt_d = IW'(1);
                    lcnt_d = LW'(1);
                end
            end
            WRITE: begin
                if (icnt == ILAST) begin
                    done_d = 1'b1;
                    icnt_d = '0;
                end else begin
                    icnt_d = icnt + IW'(1);
                end
                if (data_write_done) begin
                    we     = 1'b1;
                    wcnt_d = wcnt + CW'(1);
                end
            end
            READ_WAIT: begin
                lcnt_d = lcnt + LW'(1);
                if (lcnt == LLAST) begin
                    rd_en   = 1'b1;
                    rd_addr = base;
                    valid_d = 1'b1;
                end
            end
            READ_DATA: begin
                if (rcnt != RLAST) begin
                    rd_en   = 1'b1;
                    rd_addr = base + ADDR_WIDTH'(rcnt + CW'(1));
                    valid_d = 1'b1;
                    rcnt_d  = rcnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered counters, handshake pulses and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            base            <= '0;
            wcnt            <= '0;
            rcnt            <= '0;
            icnt            <= '0;
            lcnt            <= '0;
            data_write_done <= 1'b0;
            data_read_valid <= 1'b0;
            busy            <= 1'b0;
        end else begin
            base            <= base_d;
            wcnt            <= wcnt_d;
            rcnt            <= rcnt_d;
            icnt            <= icnt_d;
            lcnt            <= lcnt_d;
            data_write_done <= done_d;
            data_read_valid <= valid_d;
            busy            <= (next_state != IDLE);
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= data_write;
    end

    // RAM registered read port.
    always_ff @(posedge clk) begin
        if (reset)      data_read <= '0;
        else if (rd_en) data_read <= mem[rd_addr];
    end

endmodule

// File: tb/tb_sdram_command_responder.sv
// Directed plus randomized bench for sdram_command_responder, checked
// cycle by cycle against a word-array model of the memory and the
// burst timing rules.
module tb_sdram_command_responder;

    localparam int AW    = 12;
    localparam int RBL   = 8;
    localparam int WBL   = 8;
    localparam int RL    = 4;
    localparam int WI    = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  command = 2'd0;
    logic [21:0] data_address = '0;
    logic [15:0] data_write = '0;
    logic [15:0] data_read;
    logic        data_read_valid;
    logic        data_write_done;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] mem_m [DEPTH];
    bit          known [DEPTH];
    int unsigned bases [$];

    sdram_command_responder #(
        .ADDR_WIDTH         (AW),
        .READ_BURST_LENGTH  (RBL),
        .WRITE_BURST_LENGTH (WBL),
        .READ_LATENCY       (RL),
        .WRITE_INTERVAL     (WI)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .command         (command),
        .data_address    (data_address),
        .data_write      (data_write),
        .data_read       (data_read),
        .data_read_valid (data_read_valid),
        .data_write_done (data_write_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            command      = 2'd0;
            data_address = 22'($urandom);
            @(negedge clk);
            check("idle_valid", 32'(data_read_valid), 32'd0);
            check("idle_done", 32'(data_write_done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    // Write burst; cycle C is the one where command=1 is first driven.
    task automatic do_write(input logic [21:0] addr, input logic [15:0] seed,
                            input bit rnd, input bit disturb);
        int unsigned b;
        int unsigned k;
        bit          exp_done;
        logic [15:0] wd;
        b = int'(addr) % DEPTH;
        @(posedge clk); #1;
        command      = 2'd1;
        data_address = addr;
        data_write   = 16'($urandom);
        @(negedge clk);
        check("w_c_busy", 32'(busy), 32'd0);
        check("w_c_done", 32'(data_write_done), 32'd0);
        for (int j = 1; j <= WBL * WI + 1; j++) begin
            @(posedge clk); #1;
            command = (disturb && j >= 2 && j < WBL * WI) ? 2'd2 : 2'd0;
            if (disturb && j >= 2) data_address = 22'h123;
            exp_done = ((j % WI) == 0) && (j <= WBL * WI);
            if (exp_done) begin
                k  = j / WI - 1;
                wd = rnd ? 16'($urandom) : seed + 16'(k);
                data_write = wd;
                mem_m[(b + k) % DEPTH] = wd;
                known[(b + k) % DEPTH] = 1'b1;
            end else begin
                data_write = 16'($urandom);
            end
            @(negedge clk);
            check("w_done", 32'(data_write_done), 32'(exp_done));
            check("w_valid", 32'(data_read_valid), 32'd0);
            check("w_busy", 32'(busy), 32'(j <= WBL * WI));
        end
        bases.push_back(b);
    endtask

    // Read burst; abort_at>0 asserts reset during cycle C+abort_at.
    task automatic do_read(input logic [21:0] addr, input int abort_at);
        int unsigned b;
        int unsigned a;
        bit          exp_valid;
        b = int'(addr) % DEPTH;
        @(posedge clk); #1;
        command      = 2'd2;
        data_address = addr;
        @(negedge clk);
        check("r_c_busy", 32'(busy), 32'd0);
        check("r_c_valid", 32'(data_read_valid), 32'd0);
        for (int j = 1; j <= RL + RBL; j++) begin
            @(posedge clk); #1;
            command      = 2'd0;
            data_address = 22'($urandom);
            if (abort_at != 0 && j == abort_at) reset = 1'b1;
            @(negedge clk);
            exp_valid = (j >= RL) && (j < RL + RBL);
            check("r_valid", 32'(data_read_valid), 32'(exp_valid));
            check("r_done", 32'(data_write_done), 32'd0);
            check("r_busy", 32'(busy), 32'(j < RL + RBL));
            if (exp_valid) begin
                a = (b + int'(j - RL)) % DEPTH;
                if (known[a]) check("r_data", 32'(data_read), 32'(mem_m[a]));
            end
            if (abort_at != 0 && j == abort_at) begin
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check("abort_valid", 32'(data_read_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(data_write_done), 32'd0);
                check("abort_data", 32'(data_read), 32'd0);
                return;
            end
        end
    endtask

    initial begin
        logic [21:0] ra;
        foreach (known[i]) known[i] = 1'b0;

        // Reset and quiet idle.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data_read), 32'd0);
        idle(10);
        check("idle_data", 32'(data_read), 32'd0);

        // Basic write then read back.
        do_write(22'h000010, 16'h1000, 1'b0, 1'b0);
        check("model_w0", 32'(mem_m[16'h10]), 32'h1000);
        do_read(22'h000010, 0);

        // Wrap past the end of memory.
        do_write(22'h000FFC, 16'h2000, 1'b0, 1'b0);
        do_read(22'h000000, 0);
        do_read(22'h000FFC, 0);

        // Upper address bits alias.
        do_write(22'h3FF010, 16'h0, 1'b1, 1'b0);
        do_read(22'h000010, 0);

        // Command/address changes during a write are ignored.
        do_write(22'h000040, 16'h4000, 1'b0, 1'b1);
        idle(4);
        do_read(22'h000040, 0);
        do_read(22'h000123, 0);

        // Reset in the middle of a read, then a clean write/read pair.
        do_read(22'h000010, 5);
        do_write(22'h000020, 16'h1000, 1'b0, 1'b0);
        do_read(22'h000020, 0);

        // Randomized traffic with idle gaps of 0..3 cycles.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(1, 0) == 0 || bases.size() == 0) begin
                do_write(22'($urandom), 16'h0, 1'b1, 1'b0);
            end else begin
                ra = 22'(bases[$urandom_range(bases.size() - 1, 0)]
                        + $urandom_range(6, 0))
                   | (22'($urandom_range(1023, 0)) << AW);
                do_read(ra, 0);
            end
            idle(int'($urandom_range(3, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
